cache_ctrl: RTL

Sequencing controller for the direct-mapped instruction/data cache: 256 lines, 16 words per line, 32-bit word-addressed memory. It accepts one CPU read at a time and performs the tag lookup against its own tag/valid store. On a miss it refills the whole line from backing memory over a valid/ready request channel, then returns the requested word. It sits between the CPU load port and the backing memory model, and also services whole-cache invalidation (flush).

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_tag_store.sv | 46 ++++
 rtl/cache_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache sequencing controller.
//   - default address / data / index / offset widths
//   - derived tag width and words per line
//   - controller FSM state encoding
package cache_pkg;

    localparam int CACHE_ADDR_W   = 32;
    localparam int CACHE_DATA_W   = 32;
    localparam int CACHE_INDEX_W  = 8;
    localparam int CACHE_OFFSET_W = 4;
    localparam int TAG_W          = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;
    localparam int LINE_WORDS     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_RESP,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/cache_tag_store.sv
// Tag and valid store for the direct-mapped cache.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears every valid bit)
//   lookup_index_i   line index being looked up
//   lookup_tag_i     tag to compare against the stored tag
//   hit_o            line valid and stored tag matches
//   fill_en_i        write fill_tag_i at fill_index_i and mark the line valid
//   inv_en_i         clear the valid bit at inv_index_i (tag untouched)
module cache_tag_store #(
    parameter int INDEX_W  = 8,
    parameter int TAG_BITS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  lookup_index_i,
    input  logic [TAG_BITS-1:0] lookup_tag_i,
    output logic                hit_o,
    input  logic                fill_en_i,
    input  logic [INDEX_W-1:0]  fill_index_i,
    input  logic [TAG_BITS-1:0] fill_tag_i,
    input  logic                inv_en_i,
    input  logic [INDEX_W-1:0]  inv_index_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [LINES-1:0]    valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (inv_en_i) valid_q[inv_index_i] <= 1'b0;
            if (fill_en_i) valid_q[fill_index_i] <= 1'b1;
        end
    end

    // Tags are plain storage; only the valid bit decides whether a line counts.
    always_ff @(posedge clk) begin
        if (fill_en_i) tag_q[fill_index_i] <= fill_tag_i;
    end

    assign hit_o = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped read cache (256 lines x 16 words).
// Accepts one CPU read at a time, looks up the tag store, refills a whole line
// from backing memory on a miss (one beat outstanding), then returns the word.
// Also services whole-cache invalidation (flush), one index per cycle.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req_valid/ready/addr         CPU read request (word address)
//   cpu_resp_valid/data/hit          one-cycle response pulse, data, hit flag
//   flush                            one-cycle pulse, invalidate all lines
//   mem_req_valid/ready/addr         refill beat request to backing memory
//   mem_resp_valid/data              refill beat data
//   hit_count, miss_count            lookup statistics (CACHE_CTRL_STATS_EN only)
// Build option: define CACHE_CTRL_STATS_EN to add the statistics counters/ports.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = CACHE_ADDR_W,
    parameter int DATA_W   = CACHE_DATA_W,
    parameter int INDEX_W  = CACHE_INDEX_W,
    parameter int OFFSET_W = CACHE_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cpu_resp_hit,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS    = 1 << (INDEX_W + OFFSET_W);
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;
    localparam logic [INDEX_W-1:0]  LAST_LINE = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [INDEX_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]   resp_data_q;
    logic [DATA_W-1:0]   data_mem [WORDS];

    logic [TAG_BITS-1:0] tag_w;
    logic [INDEX_W-1:0]  index_w;
    logic [OFFSET_W-1:0] offset_w;
    logic                hit_w;
    logic                fill_en, inv_en, data_we, load_hit;

    assign tag_w    = addr_q[ADDR_W-1 -: TAG_BITS];
    assign index_w  = addr_q[OFFSET_W +: INDEX_W];
    assign offset_w = addr_q[OFFSET_W-1:0];

    cache_tag_store #(
        .INDEX_W  (INDEX_W),
        .TAG_BITS (TAG_BITS)
    ) u_tags (
        .clk            (clk),
        .rst            (rst),
        .lookup_index_i (index_w),
        .lookup_tag_i   (tag_w),
        .hit_o          (hit_w),
        .fill_en_i      (fill_en),
        .fill_index_i   (index_w),
        .fill_tag_i     (tag_w),
        .inv_en_i       (inv_en),
        .inv_index_i    (flush_cnt_q)
    );

    // A flush is refused here in the same cycle it is seen, so a coincident
    // request is not accepted behind the flush's back.
    assign cpu_req_ready  = (state_q == ST_IDLE) && !flush_pend_q && !flush;
    assign cpu_resp_valid = (state_q == ST_RESP);
    assign cpu_resp_hit   = resp_hit_q;
    assign cpu_resp_data  = resp_data_q;
    assign mem_req_valid  = (state_q == ST_REFILL_REQ);
    assign mem_req_addr   = (state_q == ST_REFILL_REQ) ? {addr_q[ADDR_W-1:OFFSET_W], beat_q} : '0;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        flush_cnt_d = flush_cnt_q;
        resp_hit_d  = resp_hit_q;
        fill_en     = 1'b0;
        inv_en      = 1'b0;
        data_we     = 1'b0;
        load_hit    = 1'b0;
        // Pulses outside IDLE are remembered; pulses during FLUSH are absorbed.
        flush_pend_d = flush_pend_q ||
                       (flush && (state_q != ST_IDLE) && (state_q != ST_FLUSH));
        unique case (state_q)
            ST_IDLE: begin
                if (flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = '0;
                    state_d      = ST_FLUSH;
                end else if (cpu_req_valid) begin
                    addr_d  = cpu_req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_w) begin
                    load_hit   = 1'b1;
                    resp_hit_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    beat_d  = '0;
                    state_d = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                if (mem_req_ready) state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    data_we = 1'b1;
                    // Tag/valid only become visible once the full line is in.
                    if (beat_q == LAST_BEAT) begin
                        fill_en    = 1'b1;
                        resp_hit_d = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        beat_d  = beat_q + OFFSET_W'(1);
                        state_d = ST_REFILL_REQ;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                inv_en = 1'b1;
                if (flush_cnt_q == LAST_LINE) state_d = ST_IDLE;
                else flush_cnt_d = flush_cnt_q + INDEX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
            resp_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_pend_q <= flush_pend_d;
            resp_hit_q   <= resp_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        if (data_we) data_mem[{index_w, beat_q}] <= mem_resp_data;
    end

    // On a miss the requested word is captured as its beat streams past,
    // so the response does not need a second array read.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
        end else if (load_hit) begin
            resp_data_q <= data_mem[{index_w, offset_w}];
        end else if (data_we && (beat_q == offset_w)) begin
            resp_data_q <= mem_resp_data;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit_w) hit_count_q  <= hit_count_q + 32'd1;
            else       miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
